led_pattern_decoder: RTL

- Observes the 8-bit LED bus driven by the shift/chase pattern generator and recovers the running MODE (pattern type) and Select (step-speed code).
- Sits on the observing side of the LED interface; used as a self-check monitor in hardware and as a scoreboard front-end in simulation.
- Detects each pattern step, times the interval between steps, and tracks successor-pattern streaks to lock onto a mode.

---
 rtl/led_pat_pkg.sv | 65 ++++++
 rtl/led_interval_classifier.sv | 104 ++++++++++
 rtl/led_pattern_decoder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/led_pat_pkg.sv
`default_nettype none
// ============================================================================
// Module : led_pat_pkg
// Brief  : Mode codes, converge-ring patterns and per-mode set/successor rules
// Rev    : 1.0  initial release
// ============================================================================
package led_pat_pkg;

    typedef enum logic [1:0] {
        MODE_DOT  = 2'd0,
        MODE_FILL = 2'd1,
        MODE_CONV = 2'd2
    } mode_e;

    localparam logic [7:0] CONV_P0 = 8'b1000_0001;
    localparam logic [7:0] CONV_P1 = 8'b0100_0010;
    localparam logic [7:0] CONV_P2 = 8'b0010_0100;
    localparam logic [7:0] CONV_P3 = 8'b0001_1000;

    localparam logic [2:0] STREAK_MAX = 3'd7;

    function automatic logic in_set_0(input logic [7:0] p);
        logic [3:0] ones;
        ones = 4'd0;
        for (int i = 0; i < 8; i++) begin
            ones = ones + {3'd0, p[i]};
        end
        return (ones == 4'd1);
    endfunction

    function automatic logic [7:0] succ_0(input logic [7:0] p);
        return {p[6:0], p[7]};
    endfunction

    // 2^k-1 has no bit in common with its increment; 8'hFF wraps to 0 and also qualifies
    function automatic logic in_set_1(input logic [7:0] p);
        return ((p & (p + 8'd1)) == 8'd0);
    endfunction

    function automatic logic [7:0] succ_1(input logic [7:0] p);
        return (p == 8'hFF) ? 8'h00 : {p[6:0], 1'b1};
    endfunction

    function automatic logic in_set_2(input logic [7:0] p);
        return (p == CONV_P0) || (p == CONV_P1) || (p == CONV_P2) || (p == CONV_P3);
    endfunction

    function automatic logic [7:0] succ_2(input logic [7:0] p);
        logic [7:0] n;
        case (p)
            CONV_P0: n = CONV_P1;
            CONV_P1: n = CONV_P2;
            CONV_P2: n = CONV_P3;
            CONV_P3: n = CONV_P0;
            default: n = p;
        endcase
        return n;
    endfunction

    function automatic logic in_any_set(input logic [7:0] p);
        return in_set_0(p) || in_set_1(p) || in_set_2(p);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_interval_classifier.sv
`default_nettype none
// ============================================================================
// Module : led_interval_classifier
// Brief  : Times clocks between LED steps and classifies them into a Select code
// Rev    : 1.0  initial release
// ============================================================================
module led_interval_classifier
    import led_pat_pkg::*;
#(
    parameter int CNT_W   = 26,
    parameter int DIV0    = 25000000,
    parameter int DIV1    = 12500000,
    parameter int DIV2    = 6250000,
    parameter int DIV3    = 3125000,
    parameter int TOL     = 2,
    parameter int TIMEOUT = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       timeout_clr,
    output logic [1:0] sel_out,
    output logic       sel_valid,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q, count_d;
    logic             no_ref_q, no_ref_d;
    logic             last_match_q, last_match_d;
    logic [1:0]       sel_q, sel_d;
    logic             sel_valid_q, sel_valid_d;

    logic [3:0]       w_hit;
    logic [1:0]       w_code;

    for (genvar i = 0; i < 4; i++) begin : g_code
        localparam int DIV_I = (i == 0) ? DIV0 : (i == 1) ? DIV1 : (i == 2) ? DIV2 : DIV3;
        localparam logic [CNT_W:0] LO = (DIV_I > TOL) ? (CNT_W+1)'(DIV_I - TOL) : '0;
        localparam logic [CNT_W:0] HI = (CNT_W+1)'(DIV_I + TOL);
        assign w_hit[i] = ({1'b0, count_q} >= LO) && ({1'b0, count_q} <= HI);
    end

    // A step in the same cycle always masks the stall condition
    assign timeout = !step && (count_q == TIMEOUT_V);

    always_comb begin
        w_code = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_code = 2'(i);
            end
        end
    end

    always_comb begin
        count_d      = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
        no_ref_d     = no_ref_q;
        last_match_d = last_match_q;
        sel_d        = sel_q;
        sel_valid_d  = sel_valid_q;
        if (step) begin
            count_d = CNT_ONE;
            if (no_ref_q) begin
                no_ref_d = 1'b0;
            end else if (|w_hit) begin
                sel_d        = w_code;
                sel_valid_d  = last_match_q && (sel_q == w_code);
                last_match_d = 1'b1;
            end else begin
                sel_valid_d  = 1'b0;
                last_match_d = 1'b0;
            end
        end else if (timeout || timeout_clr) begin
            no_ref_d     = 1'b1;
            sel_valid_d  = 1'b0;
            last_match_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q      <= '0;
            no_ref_q     <= 1'b1;
            last_match_q <= 1'b0;
            sel_q        <= 2'd0;
            sel_valid_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            no_ref_q     <= no_ref_d;
            last_match_q <= last_match_d;
            sel_q        <= sel_d;
            sel_valid_q  <= sel_valid_d;
        end
    end

    assign sel_out   = sel_q;
    assign sel_valid = sel_valid_q;

endmodule
`default_nettype wire

// File: rtl/led_pattern_decoder.sv
`default_nettype none
// ============================================================================
// Module : led_pattern_decoder
// Brief  : Recovers pattern MODE and Select code from an observed 8-bit LED bus
// Rev    : 1.0  initial release
// ============================================================================
module led_pattern_decoder
    import led_pat_pkg::*;
#(
    parameter int CNT_W   = 26,
    parameter int DIV0    = 25000000,
    parameter int DIV1    = 12500000,
    parameter int DIV2    = 6250000,
    parameter int DIV3    = 3125000,
    parameter int TOL     = 2,
    parameter int LOCK_N  = 4,
    parameter int TIMEOUT = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] LED,
    output logic       step_pulse,
    output logic [1:0] mode_out,
    output logic       mode_valid,
    output logic [1:0] sel_out,
    output logic       sel_valid,
    output logic       err_pulse
);

    localparam logic [2:0] LOCK_V = 3'(LOCK_N);

    logic [7:0]      led_q, led_d;
    logic [7:0]      led_prev_q, led_prev_d;
    logic [2:0][2:0] streak_q, streak_d;
    mode_e           mode_q, mode_d;
    logic            mode_valid_q, mode_valid_d;
    logic            step_pulse_q, step_pulse_d;
    logic            err_pulse_q, err_pulse_d;

    logic            w_step;
    logic            w_timeout;
    logic [2:0]      w_succ_hit;

    assign w_step = (led_q != led_prev_q);

    assign w_succ_hit[0] = in_set_0(led_prev_q) && (led_q == succ_0(led_prev_q));
    assign w_succ_hit[1] = in_set_1(led_prev_q) && (led_q == succ_1(led_prev_q));
    assign w_succ_hit[2] = in_set_2(led_prev_q) && (led_q == succ_2(led_prev_q));

    led_interval_classifier #(
        .CNT_W   (CNT_W),
        .DIV0    (DIV0),
        .DIV1    (DIV1),
        .DIV2    (DIV2),
        .DIV3    (DIV3),
        .TOL     (TOL),
        .TIMEOUT (TIMEOUT)
    ) u_interval (
        .clk         (clk),
        .reset       (reset),
        .step        (w_step),
        .timeout_clr (1'b0),
        .sel_out     (sel_out),
        .sel_valid   (sel_valid),
        .timeout     (w_timeout)
    );

    always_comb begin
        led_d        = LED;
        led_prev_d   = led_q;
        streak_d     = streak_q;
        mode_d       = mode_q;
        mode_valid_d = mode_valid_q;
        step_pulse_d = w_step;
        err_pulse_d  = w_step && !in_any_set(led_q);
        if (w_step) begin
            for (int m = 0; m < 3; m++) begin
                if (!w_succ_hit[m] || err_pulse_d) begin
                    streak_d[m] = 3'd0;
                end else if (streak_q[m] != STREAK_MAX) begin
                    streak_d[m] = streak_q[m] + 3'd1;
                end
            end
            // Descending scan so the lowest locked mode index is the one kept
            mode_valid_d = 1'b0;
            for (int m = 2; m >= 0; m--) begin
                if (streak_d[m] >= LOCK_V) begin
                    mode_valid_d = 1'b1;
                    mode_d       = mode_e'(m[1:0]);
                end
            end
        end else if (w_timeout) begin
            streak_d     = '0;
            mode_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q        <= 8'd0;
            led_prev_q   <= 8'd0;
            streak_q     <= '0;
            mode_q       <= MODE_DOT;
            mode_valid_q <= 1'b0;
            step_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            led_q        <= led_d;
            led_prev_q   <= led_prev_d;
            streak_q     <= streak_d;
            mode_q       <= mode_d;
            mode_valid_q <= mode_valid_d;
            step_pulse_q <= step_pulse_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    assign step_pulse = step_pulse_q;
    assign mode_out   = mode_q;
    assign mode_valid = mode_valid_q;
    assign err_pulse  = err_pulse_q;

endmodule
`default_nettype wire
